// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - control/status bundle between the multicycle controller and the datapath
//
// Purpose: groups the instruction fields, ALU flag, memory handshake and all
//          control strobes of the multicycle controller into one interface.
// Parameters: ALUOP_W (ALUOp width), CNT_W (RetireCount width, INSTR_COUNT_EN only)
// Modports:
//   master - controller side: reads op/func/Zero/MemReady, drives every control output
//   slave  - datapath side: drives op/func/Zero/MemReady, reads every control output
// Optional feature macro: INSTR_COUNT_EN adds RetireCount.
interface multicycle_controller_if #(
  parameter int ALUOP_W = 4
`ifdef INSTR_COUNT_EN
  , parameter int CNT_W = 32
`endif
) ();
  logic [5:0]         op;
  logic [5:0]         func;
  logic               Zero;
  logic               MemReady;
  logic               PCWrite;
  logic               IRWrite;
  logic               RegDst;
  logic               RegWrite;
  logic               ALUSrc;
  logic [ALUOP_W-1:0] ALUOp;
  logic               MemRead;
  logic               MemWrite;
  logic               IorD;
  logic               MemtoReg;
  logic [1:0]         PCSrc;
  logic               RegA;
  logic               RegB;
  logic               IllegalOp;
  logic               MemFault;
  logic               Busy;
`ifdef INSTR_COUNT_EN
  logic [CNT_W-1:0]   RetireCount;
`endif

  modport master (
    input  op, func, Zero, MemReady,
    output PCWrite, IRWrite, RegDst, RegWrite, ALUSrc, ALUOp, MemRead, MemWrite,
           IorD, MemtoReg, PCSrc, RegA, RegB, IllegalOp, MemFault, Busy
`ifdef INSTR_COUNT_EN
    , output RetireCount
`endif
  );

  modport slave (
    output op, func, Zero, MemReady,
    input  PCWrite, IRWrite, RegDst, RegWrite, ALUSrc, ALUOp, MemRead, MemWrite,
           IorD, MemtoReg, PCSrc, RegA, RegB, IllegalOp, MemFault, Busy
`ifdef INSTR_COUNT_EN
    , input RetireCount
`endif
  );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle FETCH/DECODE/EXEC/MEM/WB control unit for a MIPS-style datapath
//
// Purpose: sequences one instruction over several cycles, drives the shared
//          instruction/data memory request with a bounded ready wait, and
//          reports undecodable instructions and memory timeouts.
// Ports:
//   Clk - rising-edge clock
//   Rst - synchronous active-high reset; gates every output low while high
//   bus - multicycle_controller_if.master (instruction fields, Zero, MemReady in;
//         all control strobes, IllegalOp, MemFault, Busy out)
// Optional feature macro: INSTR_COUNT_EN adds the RetireCount counter.
module multicycle_controller #(
  parameter int ALUOP_W  = 4,
  parameter int WAIT_MAX = 15
`ifdef INSTR_COUNT_EN
  , parameter int CNT_W  = 32
`endif
) (
  input logic                    Clk,
  input logic                    Rst,
  multicycle_controller_if.master bus
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
  typedef enum logic [2:0] {C_RTYPE, C_IMM, C_LW, C_SW, C_BEQ, C_J} cls_t;

  state_t     state_q, state_d;
  cls_t       cls_q, cls_d, dec_cls;
  logic [3:0] aluop_q, aluop_d, dec_aluop;
  logic       shift_q, shift_d, dec_shift, dec_ok;
  logic       illegal_q, illegal_d;
  logic [7:0] cnt_q, cnt_d;
  logic       waiting, timeout;

  // Instruction decode; only consumed in DECODE, so later op/func changes are ignored.
  always_comb begin
    dec_cls   = C_RTYPE;
    dec_aluop = 4'b0000;
    dec_shift = 1'b0;
    dec_ok    = 1'b1;
    case (bus.op)
      6'b000000: begin
        case (bus.func)
          6'b100000: dec_aluop = 4'b0000;
          6'b100010: dec_aluop = 4'b0001;
          6'b100100: dec_aluop = 4'b0011;
          6'b100101: dec_aluop = 4'b0100;
          6'b101010: dec_aluop = 4'b0101;
          6'b000000: begin dec_aluop = 4'b1000; dec_shift = 1'b1; end
          6'b000010: begin dec_aluop = 4'b1001; dec_shift = 1'b1; end
          default:   dec_ok = 1'b0;
        endcase
      end
      6'b011100: begin
        case (bus.func)
          6'b100001: dec_aluop = 4'b1011;
          6'b100000: dec_aluop = 4'b1100;
          6'b000010: dec_aluop = 4'b0010;
          default:   dec_ok = 1'b0;
        endcase
      end
      6'b001000: dec_cls = C_IMM;
      6'b001101: begin dec_cls = C_IMM; dec_aluop = 4'b0100; end
      6'b100011: dec_cls = C_LW;
      6'b101011: dec_cls = C_SW;
      6'b000100: begin dec_cls = C_BEQ; dec_aluop = 4'b0001; end
      6'b000010: dec_cls = C_J;
      default:   dec_ok = 1'b0;
    endcase
  end

  // A wait cycle that would bring the count to WAIT_MAX is the fault cycle;
  // MemReady in that same cycle completes the access instead.
  assign waiting = (state_q == S_FETCH) || (state_q == S_MEM);
  assign timeout = waiting && !bus.MemReady && (cnt_q == 8'(WAIT_MAX - 1));

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    aluop_d   = aluop_q;
    shift_d   = shift_q;
    illegal_d = 1'b0;
    cnt_d     = cnt_q;
    if (waiting) begin
      cnt_d = (bus.MemReady || timeout) ? 8'd0 : cnt_q + 8'd1;
    end
    case (state_q)
      S_FETCH: if (bus.MemReady) state_d = S_DECODE;
      S_DECODE: begin
        if (dec_ok) begin
          cls_d   = dec_cls;
          aluop_d = dec_aluop;
          shift_d = dec_shift;
          state_d = S_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_EXEC: begin
        case (cls_q)
          C_LW, C_SW:  state_d = S_MEM;
          C_BEQ, C_J:  state_d = S_FETCH;
          default:     state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (bus.MemReady) state_d = (cls_q == C_LW) ? S_WB : S_FETCH;
        else if (timeout) state_d = S_FETCH;
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= S_FETCH;
      cls_q     <= C_RTYPE;
      aluop_q   <= 4'b0000;
      shift_q   <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      aluop_q   <= aluop_d;
      shift_q   <= shift_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  logic       pc_write, ir_write, reg_dst, reg_write, alu_src;
  logic       mem_read, mem_write, i_or_d, mem_to_reg, reg_a, reg_b, busy;
  logic [3:0] alu_op;
  logic [1:0] pc_src;

  // Controls decode from state and the latched class; only the FETCH/beq
  // strobes look at MemReady/Zero. Everything is forced low during reset so
  // an aborted instruction cannot write.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 4'b0000;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    mem_to_reg = 1'b0;
    pc_src     = 2'b00;
    reg_a      = 1'b0;
    reg_b      = 1'b0;
    busy       = 1'b0;
    if (!Rst) begin
      case (state_q)
        S_FETCH: begin
          mem_read = 1'b1;
          ir_write = bus.MemReady;
          pc_write = bus.MemReady;
        end
        S_DECODE: busy = 1'b1;
        S_EXEC: begin
          busy    = 1'b1;
          alu_op  = aluop_q;
          alu_src = (cls_q == C_IMM) || (cls_q == C_LW) || (cls_q == C_SW);
          reg_a   = shift_q;
          reg_b   = shift_q;
          if (cls_q == C_BEQ) begin
            pc_write = bus.Zero;
            pc_src   = 2'b01;
          end else if (cls_q == C_J) begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
          end
        end
        S_MEM: begin
          busy      = 1'b1;
          i_or_d    = 1'b1;
          mem_read  = (cls_q == C_LW);
          mem_write = (cls_q == C_SW);
        end
        S_WB: begin
          busy       = 1'b1;
          reg_write  = 1'b1;
          reg_dst    = (cls_q == C_RTYPE);
          mem_to_reg = (cls_q != C_LW);
        end
        default: busy = 1'b0;
      endcase
    end
  end

  assign bus.PCWrite   = pc_write;
  assign bus.IRWrite   = ir_write;
  assign bus.RegDst    = reg_dst;
  assign bus.RegWrite  = reg_write;
  assign bus.ALUSrc    = alu_src;
  assign bus.ALUOp     = ALUOP_W'(alu_op);
  assign bus.MemRead   = mem_read;
  assign bus.MemWrite  = mem_write;
  assign bus.IorD      = i_or_d;
  assign bus.MemtoReg  = mem_to_reg;
  assign bus.PCSrc     = pc_src;
  assign bus.RegA      = reg_a;
  assign bus.RegB      = reg_b;
  assign bus.Busy      = busy;
  assign bus.IllegalOp = illegal_q && !Rst;
  assign bus.MemFault  = timeout && !Rst;

`ifdef INSTR_COUNT_EN
  logic [CNT_W-1:0] retire_q, retire_d;
  logic             retire;

  // Completion points: WB exit, sw MEM exit, and every beq/j EXEC exit.
  always_comb begin
    retire   = (state_q == S_WB)
            || ((state_q == S_EXEC) && ((cls_q == C_BEQ) || (cls_q == C_J)))
            || ((state_q == S_MEM) && (cls_q == C_SW) && bus.MemReady);
    retire_d = retire ? retire_q + CNT_W'(1) : retire_q;
  end

  always_ff @(posedge Clk) begin
    if (Rst) retire_q <= '0;
    else     retire_q <= retire_d;
  end

  assign bus.RetireCount = retire_q;
`endif

endmodule
